// File: rtl/xmit_priority_sched.sv
// Two-queue transmit scheduler: picks a control word, streams its bytes, then inserts an IFG.
// Define XMIT_STARVE_GUARD_EN to let waiting low-priority frames break long high-priority runs.
module xmit_priority_sched #(
   parameter int unsigned IFG_CYCLES   = 12,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        hi_ctrl_valid,
   input  logic [11:0] hi_len,
   input  logic        lo_ctrl_valid,
   input  logic [11:0] lo_len,
   input  logic        ser_ready,
   output logic        hi_ctrl_pop,
   output logic        lo_ctrl_pop,
   output logic        hi_rd_en,
   output logic        lo_rd_en,
   output logic        sel_hi,
   output logic        tx_sof,
   output logic        tx_eof,
   output logic        busy,
   output logic        zero_len_drop
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] XFER = 2'd2;
   localparam logic [1:0] GAP  = 2'd3;

   localparam logic [7:0] IFG_INIT = 8'(IFG_CYCLES);

   logic [1:0]  state_q, state_d;
   logic        sel_hi_q, sel_hi_d;
   logic [11:0] remain_q, remain_d;
   logic [7:0]  gap_q, gap_d;
   logic        first_q, first_d;
   logic        drop_q, drop_d;
   logic        grant_hi, grant_lo;
   logic        starve_force;
   logic [11:0] load_len;
   logic        byte_ok;

`ifdef XMIT_STARVE_GUARD_EN
   logic [3:0] starve_q, starve_d;

   assign starve_force = lo_ctrl_valid && (starve_q == 4'(STARVE_LIMIT));

   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (!lo_ctrl_valid || grant_lo) begin
            starve_d = 4'd0;
         end else if (grant_hi && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic [3:0] unused_starve_limit;

   assign unused_starve_limit = 4'(STARVE_LIMIT);
   assign starve_force        = 1'b0;
`endif

   assign grant_hi = (state_q == IDLE) && hi_ctrl_valid && !starve_force;
   assign grant_lo = (state_q == IDLE) && lo_ctrl_valid && !grant_hi;
   assign load_len = sel_hi_q ? hi_len : lo_len;
   assign byte_ok  = (state_q == XFER) && ser_ready;

   always_comb begin
      state_d  = state_q;
      sel_hi_d = sel_hi_q;
      remain_d = remain_q;
      gap_d    = gap_q;
      first_d  = first_q;
      drop_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_hi || grant_lo) begin
               state_d  = LOAD;
               sel_hi_d = grant_hi;
            end
         end
         LOAD: begin
            remain_d = load_len;
            first_d  = 1'b1;
            if (load_len == 12'd0) begin
               state_d = IDLE;
               drop_d  = 1'b1;
            end else begin
               state_d = XFER;
            end
         end
         XFER: begin
            // Counter only moves on accepted bytes, so a stalled serializer loses nothing.
            if (ser_ready) begin
               first_d  = 1'b0;
               remain_d = remain_q - 12'd1;
               if (remain_q == 12'd1) begin
                  state_d = GAP;
                  gap_d   = IFG_INIT;
               end
            end
         end
         GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q == 8'd1) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= IDLE;
         sel_hi_q <= 1'b0;
         remain_q <= 12'd0;
         gap_q    <= 8'd0;
         first_q  <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_hi_q <= sel_hi_d;
         remain_q <= remain_d;
         gap_q    <= gap_d;
         first_q  <= first_d;
         drop_q   <= drop_d;
      end
   end

   assign hi_ctrl_pop   = (state_q == LOAD) && sel_hi_q;
   assign lo_ctrl_pop   = (state_q == LOAD) && !sel_hi_q;
   assign hi_rd_en      = byte_ok && sel_hi_q;
   assign lo_rd_en      = byte_ok && !sel_hi_q;
   assign tx_sof        = byte_ok && first_q;
   assign tx_eof        = byte_ok && (remain_q == 12'd1);
   assign sel_hi        = sel_hi_q;
   assign busy          = (state_q != IDLE);
   assign zero_len_drop = drop_q;

endmodule

// File: tb/tb_xmit_priority_sched.sv
// Bench for xmit_priority_sched: control FIFOs are modelled as queues of frame lengths and every
// cycle's strobes are checked against the frame currently granted.
module tb_xmit_priority_sched;

   localparam int unsigned IFG  = 12;
   localparam int unsigned SLIM = 4;

   logic        clk_sys       = 1'b0;
   logic        reset         = 1'b1;
   logic        hi_ctrl_valid = 1'b0;
   logic [11:0] hi_len        = 12'd0;
   logic        lo_ctrl_valid = 1'b0;
   logic [11:0] lo_len        = 12'd0;
   logic        ser_ready     = 1'b0;
   logic        hi_ctrl_pop, lo_ctrl_pop, hi_rd_en, lo_rd_en;
   logic        sel_hi, tx_sof, tx_eof, busy, zero_len_drop;

   xmit_priority_sched #(
      .IFG_CYCLES   (IFG),
      .STARVE_LIMIT (SLIM)
   ) dut (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .hi_ctrl_valid (hi_ctrl_valid),
      .hi_len        (hi_len),
      .lo_ctrl_valid (lo_ctrl_valid),
      .lo_len        (lo_len),
      .ser_ready     (ser_ready),
      .hi_ctrl_pop   (hi_ctrl_pop),
      .lo_ctrl_pop   (lo_ctrl_pop),
      .hi_rd_en      (hi_rd_en),
      .lo_rd_en      (lo_rd_en),
      .sel_hi        (sel_hi),
      .tx_sof        (tx_sof),
      .tx_eof        (tx_eof),
      .busy          (busy),
      .zero_len_drop (zero_len_drop)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      int          hi_n;
      int          hi_l;
      int          lo_n;
      int          lo_l;
      logic [7:0]  rdy;
      int          exp_hi_bytes;
      int          exp_lo_bytes;
      int          exp_drops;
      int          exp_grants;
      logic [15:0] exp_order;   // bit i = 1 when grant i went to high priority
   } vec_t;

   vec_t vecs[10];

   int          n_checks = 0;
   int          n_fail   = 0;
   int          hi_q[$];
   int          lo_q[$];
   logic [7:0]  rdy_pat  = 8'hFF;
   int          cyc;
   bit          in_frame, cur_hi, gap_active, drop_pend;
   int          cur_len, cur_bytes, gap_cnt;
   int          hi_bytes, lo_bytes, drops, grants, n_eof, first_pop_cyc, first_rd_cyc;
   logic [15:0] order;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_model();
      in_frame      = 1'b0;
      cur_hi        = 1'b0;
      gap_active    = 1'b0;
      drop_pend     = 1'b0;
      cur_len       = 0;
      cur_bytes     = 0;
      gap_cnt       = 0;
      hi_bytes      = 0;
      lo_bytes      = 0;
      drops         = 0;
      grants        = 0;
      n_eof         = 0;
      first_pop_cyc = -1;
      first_rd_cyc  = -1;
      order         = 16'd0;
      cyc           = 0;
   endtask

   task automatic monitor();
      bit rd, popped, drop_next;
      rd        = hi_rd_en || lo_rd_en;
      popped    = hi_ctrl_pop || lo_ctrl_pop;
      drop_next = 1'b0;
      check("zero_len_drop", int'(zero_len_drop), int'(drop_pend));
      if (zero_len_drop) begin
         drops++;
         check("busy_after_drop", int'(busy), 0);
      end
      check("dual_rd", int'(hi_rd_en && lo_rd_en), 0);
      if (gap_active) begin
         if (busy) begin
            gap_cnt++;
         end else begin
            check("gap_len", gap_cnt, IFG);
            gap_active = 1'b0;
         end
      end
      if (popped) begin
         check("dual_pop", int'(hi_ctrl_pop && lo_ctrl_pop), 0);
         check("pop_mid_frame", int'(in_frame || gap_active), 0);
         check("pop_busy", int'(busy), 1);
         check("load_no_rd", int'(rd), 0);
         cur_hi = hi_ctrl_pop;
         check("sel_hi", int'(sel_hi), int'(cur_hi));
         check("pop_nonempty", int'(cur_hi ? (hi_q.size() != 0) : (lo_q.size() != 0)), 1);
         cur_len = 0;
         if (cur_hi && hi_q.size() != 0) cur_len = hi_q.pop_front();
         else if (!cur_hi && lo_q.size() != 0) cur_len = lo_q.pop_front();
         if (grants < 16) order[grants] = cur_hi;
         grants++;
         if (first_pop_cyc < 0) first_pop_cyc = cyc;
         cur_bytes = 0;
         in_frame  = (cur_len != 0);
         drop_next = (cur_len == 0);
      end else if (in_frame) begin
         check("rd_follows_ready", int'(rd), int'(ser_ready));
      end else begin
         check("no_rd_outside_frame", int'(rd), 0);
      end
      if (rd && in_frame && !popped) begin
         check("rd_side", int'(hi_rd_en), int'(cur_hi));
         check("tx_sof", int'(tx_sof), int'(cur_bytes == 0));
         cur_bytes++;
         if (cur_hi) hi_bytes++;
         else lo_bytes++;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
         check("tx_eof", int'(tx_eof), int'(cur_bytes == cur_len));
         if (tx_eof) n_eof++;
         if (cur_bytes == cur_len) begin
            in_frame   = 1'b0;
            gap_active = 1'b1;
            gap_cnt    = 0;
         end
      end else if (!rd) begin
         check("strobe_without_rd", int'(tx_sof || tx_eof), 0);
      end
      drop_pend = drop_next;
   endtask

   // One clock: drive inputs after the falling edge, sample once they settle.
   task automatic step();
      @(negedge clk_sys);
      hi_ctrl_valid = (hi_q.size() != 0);
      hi_len        = 12'd0;
      if (hi_q.size() != 0) hi_len = 12'(hi_q[0]);
      lo_ctrl_valid = (lo_q.size() != 0);
      lo_len        = 12'd0;
      if (lo_q.size() != 0) lo_len = 12'(lo_q[0]);
      ser_ready = rdy_pat[cyc[2:0]];
      #1;
      if (!reset) monitor();
      cyc++;
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, int'({hi_ctrl_pop, lo_ctrl_pop, hi_rd_en, lo_rd_en, sel_hi,
                        tx_sof, tx_eof, busy, zero_len_drop}), 0);
   endtask

   task automatic do_reset();
      hi_q.delete();
      lo_q.delete();
      reset = 1'b1;
      repeat (6) step();
      check_outputs_zero("reset_outputs");
      reset = 1'b0;
      clear_model();
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while ((hi_q.size() != 0 || lo_q.size() != 0 || in_frame || gap_active || drop_pend
                  || busy) && n < budget);
      check("completes_in_budget", int'(n < budget), 1);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      //            hi_n hi_l lo_n lo_l rdy       hiB   loB drop gr  order
      vecs[0] = '{1,   5,   0,   0,   8'hFF,     5,    0,  0,   1,  16'h0001};
      vecs[1] = '{0,   0,   1,   7,   8'hFF,     0,    7,  0,   1,  16'h0000};
      vecs[2] = '{2,   4,   2,   4,   8'hFF,     8,    8,  0,   4,  16'h0003};
      vecs[3] = '{1,   3,   0,   0,   8'h55,     3,    0,  0,   1,  16'h0001};
      vecs[4] = '{1,   0,   0,   0,   8'hFF,     0,    0,  1,   1,  16'h0001};
      vecs[5] = '{0,   0,   3,   1,   8'hFF,     0,    3,  0,   3,  16'h0000};
      vecs[6] = '{1,   2,   1,   0,   8'hFF,     2,    0,  1,   2,  16'h0001};
      vecs[7] = '{1,   4095, 0,  0,   8'hFF,     4095, 0,  0,   1,  16'h0001};
`ifdef XMIT_STARVE_GUARD_EN
      vecs[8] = '{8,   8,   2,   8,   8'hFF,     64,   16, 0,   10, 16'h01EF};
`else
      vecs[8] = '{8,   8,   2,   8,   8'hFF,     64,   16, 0,   10, 16'h00FF};
`endif
      vecs[9] = '{1,   6,   1,   6,   8'h33,     6,    6,  0,   2,  16'h0001};

      for (int i = 0; i < 10; i++) begin
         do_reset();
         rdy_pat = vecs[i].rdy;
         for (int k = 0; k < vecs[i].hi_n; k++) hi_q.push_back(vecs[i].hi_l);
         for (int k = 0; k < vecs[i].lo_n; k++) lo_q.push_back(vecs[i].lo_l);
         run_until_idle(10000);
         check($sformatf("v%0d_hi_bytes", i), hi_bytes, vecs[i].exp_hi_bytes);
         check($sformatf("v%0d_lo_bytes", i), lo_bytes, vecs[i].exp_lo_bytes);
         check($sformatf("v%0d_drops", i), drops, vecs[i].exp_drops);
         check($sformatf("v%0d_grants", i), grants, vecs[i].exp_grants);
         check($sformatf("v%0d_order", i), int'(order), int'(vecs[i].exp_order));
      end

      // 512-byte high frame: grant latency and contiguous transfer.
      do_reset();
      rdy_pat = 8'hFF;
      hi_q.push_back(512);
      run_until_idle(2000);
      check("f512_first_pop_cycle", first_pop_cyc, 1);
      check("f512_first_rd_cycle", first_rd_cyc, 2);
      check("f512_hi_bytes", hi_bytes, 512);
      check("f512_eof_count", n_eof, 1);
      check("f512_busy_after", int'(busy), 0);

      // Zero-length word dropped, then a one-byte frame (sof and eof together).
      do_reset();
      hi_q.push_back(0);
      hi_q.push_back(1);
      run_until_idle(200);
      check("zl_drops", drops, 1);
      check("zl_hi_bytes", hi_bytes, 1);
      check("zl_grants", grants, 2);
      check("zl_eof_count", n_eof, 1);

      // Reset on byte 100 of a 512-byte frame.
      do_reset();
      hi_q.push_back(512);
      n = 0;
      while (hi_bytes < 99 && n < 300) begin
         step();
         n++;
      end
      check("mid_reached_byte99", hi_bytes, 99);
      reset = 1'b1;
      hi_q.push_back(2);
      step();
      step();
      check_outputs_zero("mid_reset_outputs");
      check("mid_no_eof", n_eof, 0);
      reset = 1'b0;
      clear_model();
      run_until_idle(200);
      check("mid_post_grants", grants, 1);
      check("mid_post_order", int'(order), 1);
      check("mid_post_hi_bytes", hi_bytes, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/xmit_priority_sched.md
XMIT_PRIORITY_SCHED -- requirements
Module: xmit_priority_sched

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles inserted after each transmitted frame (legal 1..255).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive high-priority grants allowed while low-priority waits (legal 1..15).
REQ-003 clk_sys  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 hi_ctrl_valid  input  1  high-priority control FIFO non-empty.
REQ-006 hi_len  input  12  byte length at head of high-priority control FIFO.
REQ-007 lo_ctrl_valid  input  1  low-priority control FIFO non-empty.
REQ-008 lo_len  input  12  byte length at head of low-priority control FIFO.
REQ-009 ser_ready  input  1  downstream serializer accepts one byte this cycle.
REQ-010 hi_ctrl_pop / lo_ctrl_pop  output  1 each  one-cycle pop of the selected control FIFO.
REQ-011 hi_rd_en / lo_rd_en  output  1 each  data FIFO read strobe, one byte per asserted cycle.
REQ-012 sel_hi  output  1  1 = current or last grant is high priority.
REQ-013 tx_sof / tx_eof  output  1 each  coincide with first / last byte read of a frame.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 zero_len_drop  output  1  one-cycle pulse when a zero-length control word is discarded.

Function
REQ-016 FSM states are IDLE, LOAD, XFER and GAP; state and all outputs are registered or decoded from registered state only.
REQ-017 IDLE: hi_ctrl_valid -> LOAD with sel_hi=1; else lo_ctrl_valid -> LOAD with sel_hi=0; else stay in IDLE.
REQ-018 LOAD lasts exactly one cycle: pop of selected FIFO high, selected length latched into 12-bit remaining counter.
REQ-019 LOAD with latched length 0 -> IDLE, zero_len_drop=1, no rd_en/sof/eof.
REQ-020 LOAD with length>0 -> XFER; earliest first rd_en is the cycle after LOAD (2 cycles after ctrl_valid seen in IDLE).
REQ-021 XFER: selected rd_en = ser_ready; other rd_en = 0; counter decrements only on accepted bytes; ser_ready low stalls without loss.
REQ-022 tx_sof on first accepted byte, tx_eof on the byte where counter = 1; both on same byte when length = 1; then -> GAP.
REQ-023 GAP holds exactly IFG_CYCLES cycles (8-bit down-counter), then -> IDLE; no pops or reads in GAP.
REQ-024 Arrivals during LOAD/XFER/GAP are not considered until IDLE; no preemption of a frame in progress.
REQ-025 Length 4095 (max) transmits 4095 bytes with no counter wrap.

Reset
REQ-026 On reset: state IDLE, all pops/rd_en/sof/eof/zero_len_drop/busy = 0, sel_hi = 0, counters and starve count = 0, effective next clock edge.
REQ-027 Reset mid-frame abandons the frame; no tx_eof emitted; first post-reset grant follows REQ-017.

Configuration
REQ-028 Macro XMIT_STARVE_GUARD_EN defined: 4-bit starve count increments on each high grant taken while lo_ctrl_valid = 1, clears on any low grant or lo_ctrl_valid = 0 in IDLE; when count = STARVE_LIMIT and lo_ctrl_valid = 1, IDLE grants low priority regardless of hi_ctrl_valid.
REQ-029 Macro undefined: strict priority per REQ-017; no starve counter logic synthesized.

Verification
REQ-030 Reset 6 cycles, hi_ctrl_valid=1 with hi_len=512, ser_ready=1 -> hi_ctrl_pop 1 cycle after IDLE decision, 512 contiguous hi_rd_en cycles, sof on first, eof on 512th, then 12 GAP cycles, busy low after.
REQ-031 Both queues valid, lengths 4 each, guard undefined -> all high frames first; lo_rd_en only after hi_ctrl_valid drops.
REQ-032 Guard defined, STARVE_LIMIT=4, both queues continuously valid, lengths 8 -> grant pattern H,H,H,H,L repeating.
REQ-033 hi_len=3 with ser_ready toggling 1,0,1,0,1 -> exactly 3 hi_rd_en pulses, aligned with ser_ready=1, eof on third.
REQ-034 hi_len=0 -> pop pulse then zero_len_drop pulse, no rd_en, back to IDLE without GAP; hi_len=1 next -> sof and eof same cycle.
REQ-035 reset asserted on byte 100 of 512 -> next cycle all outputs 0, state IDLE, no eof observed.
